correlator_accum: RTL and testbench



---
 rtl/correlator_accum.sv | 152 +++++++++++++++
 tb/tb_correlator_accum.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/correlator_accum.sv
// correlator_accum
//   Consumer end of the half-chip-spaced C/A replica interface. Wipes the
//   carrier and code off the IF sample stream for the early, prompt and late
//   taps on both I and Q. It integrates the six products over one C/A period
//   and latches the results at each dump. A ready/overrun handshake tells the
//   register bank when the latched set is fresh.
//
// Ports
//   clk, rstn                 system clock, async active-low reset
//   clear_enable              soft clear: zero integration state and flags
//   sample_enable             one-cycle pulse per IF sample
//   if_sign, if_mag           IF sample (sign 0 = +, mag 0 -> 1, 1 -> 3)
//   car_i_*, car_q_*          carrier replica (sign 0 = +, mag 0 -> 1, 1 -> 2)
//   early, prompt, late       code chips (0 -> +1, 1 -> -1)
//   dump_enable               C/A period boundary pulse
//   read_ack                  register bank has read the six outputs
//   i_/q_ early/prompt/late   latched signed correlations (two's complement)
//   accum_ready               a new correlation set is available
//   overrun                   sticky: a set was overwritten before being read

module correlator_accum #(
  parameter int ACC_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 clear_enable,
  input  logic                 sample_enable,
  input  logic                 if_sign,
  input  logic                 if_mag,
  input  logic                 car_i_sign,
  input  logic                 car_q_sign,
  input  logic                 car_i_mag,
  input  logic                 car_q_mag,
  input  logic                 early,
  input  logic                 prompt,
  input  logic                 late,
  input  logic                 dump_enable,
  input  logic                 read_ack,
  output logic [ACC_WIDTH-1:0] i_early,
  output logic [ACC_WIDTH-1:0] q_early,
  output logic [ACC_WIDTH-1:0] i_prompt,
  output logic [ACC_WIDTH-1:0] q_prompt,
  output logic [ACC_WIDTH-1:0] i_late,
  output logic [ACC_WIDTH-1:0] q_late,
  output logic                 accum_ready,
  output logic                 overrun
);

  localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  // Sample magnitude {1,3} times carrier magnitude {1,2} gives {1,2,3,6}.
  function automatic logic [2:0] prod_mag(input logic s_mag, input logic c_mag);
    logic [2:0] m;
    case ({s_mag, c_mag})
      2'b00:   m = 3'd1;
      2'b01:   m = 3'd2;
      2'b10:   m = 3'd3;
      default: m = 3'd6;
    endcase
    return m;
  endfunction

  logic [2:0] i_mag;
  logic [2:0] q_mag;
  logic       i_neg;
  logic       q_neg;
  logic [2:0] taps;

  assign i_mag = prod_mag(if_mag, car_i_mag);
  assign q_mag = prod_mag(if_mag, car_q_mag);
  assign i_neg = if_sign ^ car_i_sign;
  assign q_neg = if_sign ^ car_q_sign;
  assign taps  = {late, prompt, early};

  // Channel order: 0 ie, 1 qe, 2 ip, 3 qp, 4 il, 5 ql
  for (genvar k = 0; k < 6; k++) begin : g_ch
    localparam int TAP = k / 2;
    localparam bit IS_Q = (k % 2) == 1;

    logic                        neg;
    logic [2:0]                  mag;
    logic signed [ACC_WIDTH:0]   contrib;
    logic signed [ACC_WIDTH:0]   sum;
    logic signed [ACC_WIDTH-1:0] sat_sum;
    logic signed [ACC_WIDTH-1:0] acc;
    logic signed [ACC_WIDTH-1:0] latched;

    assign mag = IS_Q ? q_mag : i_mag;
    // A code chip of 1 is -1, so it simply flips the product sign.
    assign neg = (IS_Q ? q_neg : i_neg) ^ taps[TAP];

    assign contrib = neg ? -$signed({{(ACC_WIDTH-2){1'b0}}, mag})
                         :  $signed({{(ACC_WIDTH-2){1'b0}}, mag});

    // One guard bit catches overflow; the two top bits disagree on overflow.
    assign sum = $signed({acc[ACC_WIDTH-1], acc}) + contrib;

    always_comb begin
      sat_sum = sum[ACC_WIDTH-1:0];
      if (sum[ACC_WIDTH] != sum[ACC_WIDTH-1]) begin
        sat_sum = sum[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
      end
    end

    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        acc     <= '0;
        latched <= '0;
      end else if (clear_enable) begin
        acc <= '0;
      end else if (dump_enable) begin
        // A sample landing on the dump edge opens the new period.
        latched <= acc;
        acc     <= sample_enable ? contrib[ACC_WIDTH-1:0] : '0;
      end else if (sample_enable) begin
        acc <= sat_sum;
      end
    end
  end

  assign i_early  = g_ch[0].latched;
  assign q_early  = g_ch[1].latched;
  assign i_prompt = g_ch[2].latched;
  assign q_prompt = g_ch[3].latched;
  assign i_late   = g_ch[4].latched;
  assign q_late   = g_ch[5].latched;

  // A dump always wins over read_ack. Overrun is raised only when an unread
  // set gets overwritten. A read_ack on the same edge as the dump counts as
  // reading the old set in time, so no overrun is flagged.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      accum_ready <= 1'b0;
      overrun     <= 1'b0;
    end else if (clear_enable) begin
      accum_ready <= 1'b0;
      overrun     <= 1'b0;
    end else if (dump_enable) begin
      accum_ready <= 1'b1;
      if (accum_ready && !read_ack) begin
        overrun <= 1'b1;
      end else if (read_ack) begin
        overrun <= 1'b0;
      end
    end else if (read_ack) begin
      accum_ready <= 1'b0;
      overrun     <= 1'b0;
    end
  end

endmodule

// File: tb/tb_correlator_accum.sv
module tb_correlator_accum;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        clear_enable = 1'b0;
  logic        sample_enable = 1'b0;
  logic        if_sign = 1'b0, if_mag = 1'b0;
  logic        car_i_sign = 1'b0, car_q_sign = 1'b0;
  logic        car_i_mag = 1'b0, car_q_mag = 1'b0;
  logic        early = 1'b0, prompt = 1'b0, late = 1'b0;
  logic        dump_enable = 1'b0;
  logic        read_ack = 1'b0;
  logic [15:0] i_early, q_early, i_prompt, q_prompt, i_late, q_late;
  logic        accum_ready, overrun;

  logic signed [15:0] dout [6];
  assign dout[0] = i_early;
  assign dout[1] = q_early;
  assign dout[2] = i_prompt;
  assign dout[3] = q_prompt;
  assign dout[4] = i_late;
  assign dout[5] = q_late;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: integer accumulators with clamping.
  int macc [6];
  int mout [6];
  bit mready;
  bit movr;

  correlator_accum #(.ACC_WIDTH(16)) dut (
    .clk(clk), .rstn(rstn), .clear_enable(clear_enable),
    .sample_enable(sample_enable), .if_sign(if_sign), .if_mag(if_mag),
    .car_i_sign(car_i_sign), .car_q_sign(car_q_sign),
    .car_i_mag(car_i_mag), .car_q_mag(car_q_mag),
    .early(early), .prompt(prompt), .late(late),
    .dump_enable(dump_enable), .read_ack(read_ack),
    .i_early(i_early), .q_early(q_early), .i_prompt(i_prompt),
    .q_prompt(q_prompt), .i_late(i_late), .q_late(q_late),
    .accum_ready(accum_ready), .overrun(overrun)
  );

  always #5 clk = ~clk;

  function automatic int clamp(input int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  // Real-valued product of sample, carrier and code chip for channel k.
  function automatic int product(input int k);
    int s, c, code;
    bit chip;
    s = (if_mag ? 3 : 1) * (if_sign ? -1 : 1);
    if (k % 2 == 0) c = (car_i_mag ? 2 : 1) * (car_i_sign ? -1 : 1);
    else            c = (car_q_mag ? 2 : 1) * (car_q_sign ? -1 : 1);
    chip = (k / 2 == 0) ? early : (k / 2 == 1) ? prompt : late;
    code = chip ? -1 : 1;
    return s * c * code;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 6; k++) begin
      macc[k] = 0;
      mout[k] = 0;
    end
    mready = 0;
    movr   = 0;
  endtask

  // Advance one clock with the given control pulses, updating the model.
  task automatic cycle(input bit smp, input bit dmp, input bit clr, input bit ack);
    sample_enable = smp;
    dump_enable   = dmp;
    clear_enable  = clr;
    read_ack      = ack;
    @(posedge clk);
    if (clr) begin
      for (int k = 0; k < 6; k++) macc[k] = 0;
      mready = 0;
      movr   = 0;
    end else if (dmp) begin
      for (int k = 0; k < 6; k++) begin
        mout[k] = macc[k];
        macc[k] = smp ? product(k) : 0;
      end
      if (mready && !ack) movr = 1;
      else if (ack)       movr = 0;
      mready = 1;
    end else begin
      if (smp) for (int k = 0; k < 6; k++) macc[k] = clamp(macc[k] + product(k));
      if (ack) begin
        mready = 0;
        movr   = 0;
      end
    end
    #1;
    sample_enable = 0;
    dump_enable   = 0;
    clear_enable  = 0;
    read_ack      = 0;
  endtask

  task automatic set_const();
    if_sign = 0; if_mag = 1;
    car_i_sign = 0; car_i_mag = 1;
    car_q_sign = 1; car_q_mag = 0;
    early = 0; prompt = 1; late = 0;
  endtask

  task automatic test_reset();
    model_reset();
    rstn = 0;
    repeat (2) @(posedge clk);
    #1;
    rstn = 1;
    n_tests++;
    if (accum_ready !== 1'b0 || overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags: ready=%b overrun=%b, want 0 0", accum_ready, overrun);
    end
    for (int k = 0; k < 6; k++) begin
      n_tests++;
      if (dout[k] !== 16'sd0) begin
        n_fail++;
        $display("FAIL reset_out[%0d]: got %0d want 0", k, dout[k]);
      end
    end
    set_const();
    repeat (4) cycle(1, 0, 0, 0);
    cycle(0, 1, 0, 0);
    repeat (10) cycle(1, 0, 0, 0);
    n_tests++;
    if (dout[0] !== 16'sd24 || accum_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_reset: i_early=%0d ready=%b want 24 1", dout[0], accum_ready);
    end
    #2;
    rstn = 0;
    #1;
    model_reset();
    n_tests++;
    if (accum_ready !== 1'b0 || overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset_flags: ready=%b overrun=%b want 0 0", accum_ready, overrun);
    end
    for (int k = 0; k < 6; k++) begin
      n_tests++;
      if (dout[k] !== 16'sd0) begin
        n_fail++;
        $display("FAIL async_reset_out[%0d]: got %0d want 0", k, dout[k]);
      end
    end
    #1;
    rstn = 1;
  endtask

  task automatic test_constant();
    int expv [6] = '{6000, -3000, -6000, 3000, 6000, -3000};
    set_const();
    repeat (1000) cycle(1, 0, 0, 0);
    n_tests++;
    if (accum_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL const_ready_before: got %b want 0", accum_ready);
    end
    cycle(0, 1, 0, 0);
    n_tests++;
    if (accum_ready !== 1'b1 || overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL const_ready_after: ready=%b overrun=%b want 1 0", accum_ready, overrun);
    end
    for (int k = 0; k < 6; k++) begin
      n_tests++;
      if (dout[k] !== expv[k]) begin
        n_fail++;
        $display("FAIL const_out[%0d]: got %0d want %0d", k, dout[k], expv[k]);
      end
    end
  endtask

  task automatic test_coincident();
    set_const();
    cycle(0, 0, 0, 1);
    repeat (5) cycle(1, 0, 0, 0);
    cycle(1, 1, 0, 0);
    n_tests++;
    if (dout[0] !== 16'sd30 || dout[2] !== -16'sd30) begin
      n_fail++;
      $display("FAIL coinc_first: i_early=%0d i_prompt=%0d want 30 -30", dout[0], dout[2]);
    end
    cycle(0, 0, 0, 1);
    cycle(0, 1, 0, 0);
    n_tests++;
    if (dout[0] !== 16'sd6 || dout[3] !== 16'sd3) begin
      n_fail++;
      $display("FAIL coinc_second: i_early=%0d q_prompt=%0d want 6 3", dout[0], dout[3]);
    end
  endtask

  task automatic test_saturation();
    set_const();
    cycle(0, 0, 0, 1);
    repeat (5462) cycle(1, 0, 0, 0);
    cycle(0, 1, 0, 0);
    n_tests++;
    if (dout[0] !== 16'sd32767 || dout[4] !== 16'sd32767) begin
      n_fail++;
      $display("FAIL sat_pos: i_early=%0d i_late=%0d want 32767", dout[0], dout[4]);
    end
    n_tests++;
    if (dout[2] !== -16'sd32768) begin
      n_fail++;
      $display("FAIL sat_neg: i_prompt=%0d want -32768", dout[2]);
    end
    n_tests++;
    if (dout[1] !== -16'sd16386 || dout[3] !== 16'sd16386) begin
      n_fail++;
      $display("FAIL sat_q: q_early=%0d q_prompt=%0d want -16386 16386", dout[1], dout[3]);
    end
  endtask

  task automatic test_handshake();
    set_const();
    cycle(0, 0, 0, 1);
    repeat (3) cycle(1, 0, 0, 0);
    cycle(0, 1, 0, 0);
    early = 1;
    repeat (2) cycle(1, 0, 0, 0);
    cycle(0, 1, 0, 0);
    n_tests++;
    if (overrun !== 1'b1 || accum_ready !== 1'b1 || dout[0] !== -16'sd12) begin
      n_fail++;
      $display("FAIL hs_overrun: ovr=%b ready=%b i_early=%0d want 1 1 -12",
               overrun, accum_ready, dout[0]);
    end
    cycle(0, 0, 0, 1);
    n_tests++;
    if (accum_ready !== 1'b0 || overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL hs_ack: ready=%b ovr=%b want 0 0", accum_ready, overrun);
    end
    repeat (2) cycle(1, 0, 0, 0);
    cycle(0, 1, 0, 0);
    cycle(1, 1, 0, 1);
    n_tests++;
    if (accum_ready !== 1'b1 || overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL hs_ack_dump: ready=%b ovr=%b want 1 0", accum_ready, overrun);
    end
    n_tests++;
    if (dout[0] !== -16'sd0 || dout[2] !== 16'sd0) begin
      n_fail++;
      $display("FAIL hs_ack_dump_out: i_early=%0d i_prompt=%0d want 0 0", dout[0], dout[2]);
    end
  endtask

  task automatic test_clear();
    logic signed [15:0] saved [6];
    set_const();
    cycle(0, 0, 0, 1);
    repeat (4) cycle(1, 0, 0, 0);
    cycle(0, 1, 0, 0);
    for (int k = 0; k < 6; k++) saved[k] = dout[k];
    repeat (3) cycle(1, 0, 0, 0);
    cycle(1, 1, 1, 0);
    n_tests++;
    if (accum_ready !== 1'b0 || overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_flags: ready=%b ovr=%b want 0 0", accum_ready, overrun);
    end
    for (int k = 0; k < 6; k++) begin
      n_tests++;
      if (dout[k] !== saved[k]) begin
        n_fail++;
        $display("FAIL clear_hold[%0d]: got %0d want %0d", k, dout[k], saved[k]);
      end
    end
    cycle(0, 1, 0, 0);
    for (int k = 0; k < 6; k++) begin
      n_tests++;
      if (dout[k] !== 16'sd0) begin
        n_fail++;
        $display("FAIL clear_next_dump[%0d]: got %0d want 0", k, dout[k]);
      end
    end
  endtask

  task automatic test_random();
    int bad;
    for (int n = 0; n < 600; n++) begin
      {if_sign, if_mag, car_i_sign, car_i_mag, car_q_sign, car_q_mag,
       early, prompt, late} = 9'($urandom);
      cycle($urandom_range(3, 0) != 0, $urandom_range(19, 0) == 0,
            $urandom_range(59, 0) == 0, $urandom_range(7, 0) == 0);
      bad = 0;
      for (int k = 0; k < 6; k++) if (dout[k] !== mout[k]) bad++;
      n_tests++;
      if (bad != 0 || accum_ready !== mready || overrun !== movr) begin
        n_fail++;
        $display("FAIL random[%0d]: out=%0d,%0d,%0d,%0d,%0d,%0d rdy=%b ovr=%b want %0d,%0d,%0d,%0d,%0d,%0d rdy=%b ovr=%b",
                 n, dout[0], dout[1], dout[2], dout[3], dout[4], dout[5], accum_ready, overrun,
                 mout[0], mout[1], mout[2], mout[3], mout[4], mout[5], mready, movr);
      end
    end
    // A long run pushes the accumulators into saturation under random signs.
    set_const();
    cycle(0, 0, 0, 1);
    repeat (6000) cycle(1, 0, 0, 0);
    for (int n = 0; n < 200; n++) begin
      {if_sign, car_i_sign, car_q_sign, early, prompt, late} = 6'($urandom);
      cycle(1, $urandom_range(29, 0) == 0, 1'b0, $urandom_range(3, 0) == 0);
      bad = 0;
      for (int k = 0; k < 6; k++) if (dout[k] !== mout[k]) bad++;
      n_tests++;
      if (bad != 0 || accum_ready !== mready || overrun !== movr) begin
        n_fail++;
        $display("FAIL random_sat[%0d]: out=%0d,%0d,%0d rdy=%b ovr=%b want %0d,%0d,%0d rdy=%b ovr=%b",
                 n, dout[0], dout[2], dout[4], accum_ready, overrun,
                 mout[0], mout[2], mout[4], mready, movr);
      end
    end
  endtask

  initial begin
    test_reset();
    test_constant();
    test_coincident();
    test_saturation();
    test_handshake();
    test_clear();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
